// File: rtl/gpr_dump_unit.sv
// Streams GPR[FIRST_REG..LAST_REG] as {index, data} beats over valid/ready via a spare read port.
// Define DUMP_CHECKSUM_EN to append a final XOR-checksum beat (index 0) to every dump.
module gpr_dump_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned FIRST_REG  = 1,
   parameter int unsigned LAST_REG   = 31
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rf_raddr,
   input  logic [DATA_WIDTH-1:0] rf_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);

`ifdef DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, HOLD, SUM, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, HOLD, DONE} state_t;
`endif

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
   logic                    out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0]   out_index_q, out_index_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_last_q, out_last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   acc_q, acc_d;
`endif

   always_comb begin
      state_d     = state_q;
      raddr_d     = raddr_q;
      out_valid_d = out_valid_q;
      out_index_d = out_index_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc_d       = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               raddr_d = FIRST_IDX;
               busy_d  = 1'b1;
`ifdef DUMP_CHECKSUM_EN
               acc_d   = '0;
`endif
               state_d = LOAD;
            end
         end
         LOAD: begin
            out_data_d  = rf_rdata;
            out_index_d = raddr_q;
            out_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
            out_last_d  = 1'b0;
            acc_d       = acc_q ^ rf_rdata;
`else
            out_last_d  = (raddr_q == LAST_IDX);
`endif
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               // out_last only ever marks the true final beat, so it alone selects DONE.
               if (out_last_q) begin
                  out_last_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = DONE;
               end else if (raddr_q < LAST_IDX) begin
                  raddr_d = raddr_q + 1'b1;
                  state_d = LOAD;
               end else begin
`ifdef DUMP_CHECKSUM_EN
                  state_d = SUM;
`else
                  done_d  = 1'b1;
                  state_d = DONE;
`endif
               end
            end
         end
`ifdef DUMP_CHECKSUM_EN
         SUM: begin
            out_index_d = '0;
            out_data_d  = acc_q;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
`endif
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         raddr_q     <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         acc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef DUMP_CHECKSUM_EN
         acc_q       <= acc_d;
`endif
      end
   end

   assign rf_raddr  = raddr_q;
   assign out_valid = out_valid_q;
   assign out_index = out_index_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_gpr_dump_unit.sv
// Scoreboard bench for gpr_dump_unit: default-parameter instance plus a single-register (5..5) instance.
module tb_gpr_dump_unit;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start0, start1, ready0, ready1;
   logic [4:0]  raddr0, raddr1, index0, index1;
   logic [31:0] rdata0, rdata1, data0, data1;
   logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;

   logic [31:0] gpr0 [32];
   logic [31:0] gpr1 [32];

   beat_t q0[$];
   beat_t q1[$];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt0 = 0, done_cnt1 = 0, exp_done0 = 0, exp_done1 = 0;
   int last_hs0 = -10, last_hs1 = -10;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   assign rdata0 = gpr0[raddr0];
   assign rdata1 = gpr1[raddr1];

   gpr_dump_unit dut0 (
      .clock(clock), .reset(reset), .start(start0),
      .rf_raddr(raddr0), .rf_rdata(rdata0),
      .out_valid(valid0), .out_ready(ready0), .out_index(index0),
      .out_data(data0), .out_last(last0), .busy(busy0), .done(done0)
   );

   gpr_dump_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIRST_REG(5), .LAST_REG(5)) dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .rf_raddr(raddr1), .rf_rdata(rdata1),
      .out_valid(valid1), .out_ready(ready1), .out_index(index1),
      .out_data(data1), .out_last(last1), .busy(busy1), .done(done1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Expected beats for one complete dump of the selected instance.
   task automatic push_dump(input int which);
      logic [31:0] acc;
      beat_t b;
      int f, l;
      acc = '0;
      f = (which != 0) ? 5 : 1;
      l = (which != 0) ? 5 : 31;
      for (int i = f; i <= l; i++) begin
         b.idx  = i[4:0];
         b.data = (which != 0) ? gpr1[i] : gpr0[i];
         acc    = acc ^ b.data;
`ifdef DUMP_CHECKSUM_EN
         b.last = 1'b0;
`else
         b.last = (i == l);
`endif
         if (which != 0) q1.push_back(b); else q0.push_back(b);
      end
`ifdef DUMP_CHECKSUM_EN
      b.idx = '0; b.data = acc; b.last = 1'b1;
      if (which != 0) q1.push_back(b); else q0.push_back(b);
`endif
      if (which != 0) exp_done1++; else exp_done0++;
   endtask

   always @(negedge clock) begin
      beat_t e;
      if (reset) begin
         if (valid0 && ready0) begin
            if (q0.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL beat0_unexpected actual=%0h/%0h expected=none", index0, data0);
            end else begin
               e = q0.pop_front();
               check("beat0", {25'd0, index0, data0, last0}, {25'd0, e});
               if (e.last) last_hs0 = cyc;
            end
         end
         if (valid1 && ready1) begin
            if (q1.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL beat1_unexpected actual=%0h/%0h expected=none", index1, data1);
            end else begin
               e = q1.pop_front();
               check("beat1", {25'd0, index1, data1, last1}, {25'd0, e});
               if (e.last) last_hs1 = cyc;
            end
         end
         if (done0) begin
            done_cnt0++;
            check("done0_latency", 64'(cyc), 64'(last_hs0 + 1));
         end
         if (done1) begin
            done_cnt1++;
            check("done1_latency", 64'(cyc), 64'(last_hs1 + 1));
         end
      end
   end

   task automatic pulse_start(input int which, input logic chk_latency);
      int n;
      if (which != 0) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clock); #1;
      start0 = 1'b0; start1 = 1'b0;
      n = 1;
      while (!((which != 0) ? valid1 : valid0) && n < 10) begin
         @(posedge clock); #1;
         n++;
      end
      if (chk_latency) check("first_valid_latency", 64'(n), 64'd2);
   endtask

   task automatic wait_beat0(input int idx, input int limit);
      int n;
      n = 0;
      while (!(valid0 && index0 == idx[4:0]) && n < limit) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= limit) begin
         n_checks++; n_fail++;
         $display("FAIL wait_beat0 timeout actual=none expected=index %0d", idx);
      end
   endtask

   task automatic wait_idle(input int which, input int limit);
      int n;
      n = 0;
      while (((which != 0) ? busy1 : busy0) && n < limit) begin
         @(posedge clock); #1;
         n++;
      end
      check("idle_timeout", 64'(n >= limit), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      if (which != 0) begin
         check("q1_drained", 64'(q1.size()), 64'd0);
         check("done1_count", 64'(done_cnt1), 64'(exp_done1));
         check("busy1_after", {63'd0, busy1}, 64'd0);
      end else begin
         check("q0_drained", 64'(q0.size()), 64'd0);
         check("done0_count", 64'(done_cnt0), 64'(exp_done0));
         check("busy0_after", {62'd0, busy0, valid0}, 64'd0);
      end
   endtask

   initial begin
      reset = 1'b0; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         gpr0[i] = i;
         gpr1[i] = 32'hA5A5_0000 + i;
      end
      gpr1[5] = 32'hDEAD_BEEF;
      repeat (3) @(posedge clock);
      #1;
      check("reset_state0", {18'd0, raddr0, valid0, index0, data0, last0, busy0, done0}, 64'd0);
      check("reset_state1", {18'd0, raddr1, valid1, index1, data1, last1, busy1, done1}, 64'd0);
      reset = 1'b1;
      @(posedge clock); #1;

      // Full dump, ready held high
      push_dump(0);
      pulse_start(0, 1'b1);
      wait_idle(0, 200);

      // Backpressure on index 4, then an ignored start at index 7
      push_dump(0);
      pulse_start(0, 1'b1);
      wait_beat0(4, 100);
      ready0 = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("bp_hold", {26'd0, valid0, index0, data0}, {26'd0, 1'b1, 5'd4, 32'd4});
      end
      @(posedge clock); #1;
      ready0 = 1'b1;
      wait_beat0(7, 100);
      start0 = 1'b1;
      @(posedge clock); #1;
      start0 = 1'b0;
      wait_idle(0, 200);

      // Reset mid-dump at index 10
      push_dump(0);
      pulse_start(0, 1'b1);
      wait_beat0(10, 100);
      ready0 = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("abort_outputs", {25'd0, valid0, busy0, done0, index0, data0}, 64'd0);
      q0.delete();
      exp_done0--;
      @(posedge clock); #1;
      reset = 1'b1;
      ready0 = 1'b1;
      @(posedge clock); #1;
      push_dump(0);
      pulse_start(0, 1'b1);
      wait_idle(0, 200);

      // Single-register instance
      push_dump(1);
      pulse_start(1, 1'b1);
      wait_idle(1, 50);

      // Altered register contents
      gpr0[5] = 32'h0000_00FF;
      push_dump(0);
      pulse_start(0, 1'b1);
      wait_idle(0, 200);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
